cnt_snap_buf: RTL and testbench

CNT_SNAP_BUF -- requirements
Module: cnt_snap_buf

---
 rtl/cnt_snap_pkg.sv | 19 +
 rtl/cnt_snap_fifo.sv | 75 +++++++
 rtl/cnt_snap_buf.sv | 97 +++++++++
 tb/tb_cnt_snap_buf.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cnt_snap_pkg.sv
// Shared types and defaults for the counter snapshot buffer.
// Holds the entry struct, the source-bit positions and the default sizes.
package cnt_snap_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int DEPTH_DEF = 4;
  // Widest counter value an entry can carry.
  localparam int DATA_MAX  = 16;

  localparam int SRC_ROLL  = 0;
  localparam int SRC_REQ   = 1;

  typedef struct packed {
    logic [DATA_MAX-1:0] data;
    logic [1:0]          src;
    logic                dir;
  } entry_t;

endpackage

// File: rtl/cnt_snap_fifo.sv
// Entry storage for the snapshot buffer: DEPTH-deep FIFO of entry_t.
// Ports: push/wdata in, pop/rdata out, level/full/empty status, dropped flag.
module cnt_snap_fifo
  import cnt_snap_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  entry_t        wdata,
  input  logic          pop,
  output entry_t        rdata,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty,
  output logic          dropped
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign do_pop  = pop & ~empty;
  // A pop frees the slot at the same edge, so full does not block.
  assign do_push = push & (~full | do_pop);
  assign dropped = push & full & ~do_pop;
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case (1'b1)
      do_push & ~do_pop: level_d = level_q + LW'(1);
      do_pop & ~do_push: level_d = level_q - LW'(1);
      default:           level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/cnt_snap_buf.sv
// Snapshot buffer: records counter value on rollover rise or manual request.
// Ports: count/rollover/down/snap_req in; out_* valid/ready head; level/full/empty.
// Optional: define CNT_SNAP_DROP_CNT_EN to add the 8-bit saturating drop_cnt.
module cnt_snap_buf
  import cnt_snap_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [WIDTH-1:0]           count,
  input  logic                       rollover,
  input  logic                       down,
  input  logic                       snap_req,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [1:0]                 out_src,
  output logic                       out_dir,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty
`ifdef CNT_SNAP_DROP_CNT_EN
  , output logic [7:0]               drop_cnt
`endif
);

  logic   roll_q, roll_d;
  logic   roll_ev;
  logic   push;
  logic   pop;
  logic   dropped;
  entry_t in_e;
  entry_t head;

  // Only the rising edge of the all-ones flag is an event.
  assign roll_ev = rollover & ~roll_q;
  assign roll_d  = rollover;
  assign push    = roll_ev | snap_req;
  assign pop     = out_valid & out_ready;

  always_comb begin
    in_e               = '0;
    in_e.data          = DATA_MAX'(count);
    in_e.src[SRC_ROLL] = roll_ev;
    in_e.src[SRC_REQ]  = snap_req;
    in_e.dir           = down;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) roll_q <= 1'b0;
    else       roll_q <= roll_d;
  end

  cnt_snap_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push    (push),
    .wdata   (in_e),
    .pop     (pop),
    .rdata   (head),
    .level   (level),
    .full    (full),
    .empty   (empty),
    .dropped (dropped)
  );

  assign out_valid = ~empty;
  assign out_data  = WIDTH'(head.data);
  assign out_src   = head.src;
  assign out_dir   = head.dir;

`ifdef CNT_SNAP_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (dropped && drop_cnt_q != 8'hFF) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) drop_cnt_q <= 8'd0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  logic unused_dropped;
  assign unused_dropped = dropped;
`endif

endmodule

// File: tb/tb_cnt_snap_buf.sv
// Self-checking bench for cnt_snap_buf: directed steps plus random traffic
// compared against a queue-based reference model.
module tb_cnt_snap_buf;

  localparam int W = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rstn;
  logic [W-1:0] count;
  logic         rollover;
  logic         down;
  logic         snap_req;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_src;
  logic         out_dir;
  logic [2:0]   level;
  logic         full;
  logic         empty;
`ifdef CNT_SNAP_DROP_CNT_EN
  logic [7:0]   drop_cnt;
`endif

  always #5 clk = ~clk;

  cnt_snap_buf #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .count     (count),
    .rollover  (rollover),
    .down      (down),
    .snap_req  (snap_req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_dir   (out_dir),
    .level     (level),
    .full      (full),
    .empty     (empty)
`ifdef CNT_SNAP_DROP_CNT_EN
    , .drop_cnt (drop_cnt)
`endif
  );

  typedef struct {
    logic [W-1:0] d;
    logic [1:0]   s;
    logic         dir;
  } m_ent_t;

  m_ent_t mq[$];
  logic   m_roll;
  int     m_drop;
  int     total;
  int     passed;
  int     fails;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behaviour of one rising edge, from the buffer's rules.
  task automatic model_edge();
    bit ev;
    m_ent_t e;
    if (!rstn) begin
      mq.delete();
      m_roll = 1'b0;
      m_drop = 0;
      return;
    end
    ev     = rollover && !m_roll;
    m_roll = rollover;
    if (mq.size() > 0 && out_ready) void'(mq.pop_front());
    if (ev || snap_req) begin
      if (mq.size() < D) begin
        e.d   = count;
        e.s   = {snap_req, ev};
        e.dir = down;
        mq.push_back(e);
      end else if (m_drop < 255) begin
        m_drop++;
      end
    end
  endtask

  task automatic check_all();
    bit ne;
    ne = mq.size() > 0;
    chk("out_valid", 32'(out_valid), 32'(ne));
    chk("out_data", 32'(out_data), ne ? 32'(mq[0].d) : 0);
    chk("out_src", 32'(out_src), ne ? 32'(mq[0].s) : 0);
    chk("out_dir", 32'(out_dir), ne ? 32'(mq[0].dir) : 0);
    chk("level", 32'(level), 32'(mq.size()));
    chk("full", 32'(full), 32'(mq.size() == D));
    chk("empty", 32'(empty), 32'(!ne));
`ifdef CNT_SNAP_DROP_CNT_EN
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
  endtask

  // Called away from the rising edge; returns at the next falling edge.
  task automatic step(input logic [W-1:0] c, input logic ro,
                      input logic dn, input logic sr, input logic rdy);
    count     = c;
    rollover  = ro;
    down      = dn;
    snap_req  = sr;
    out_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    @(negedge clk);
  endtask

  m_ent_t hold;
  logic   r_roll;

  initial begin
    total = 0; passed = 0; fails = 0;
    rstn = 1'b0; count = '0; rollover = 1'b0;
    down = 1'b0; snap_req = 1'b0; out_ready = 1'b0;
    mq.delete(); m_roll = 1'b0; m_drop = 0;
    #1;
    check_all();
    @(negedge clk);
    rstn = 1'b1;

    // Held rollover: one entry, visible right after the push edge.
    step(4'hE, 0, 0, 0, 1);
    step(4'hF, 1, 0, 0, 1);
    chk("roll_data", 32'(out_data), 32'hF);
    chk("roll_src", 32'(out_src), 32'h1);
    step(4'hF, 1, 0, 0, 1);
    step(4'hF, 1, 0, 0, 1);
    chk("roll_once", 32'(level), 32'h0);
    step(4'h0, 0, 0, 0, 1);

    // Coincident rollover rise and request: single entry, both bits.
    step(4'hF, 1, 1, 1, 0);
    chk("both_src", 32'(out_src), 32'h3);
    chk("both_dir", 32'(out_dir), 32'h1);
    chk("both_lvl", 32'(level), 32'h1);
    step(4'h0, 0, 0, 0, 1);

    // Fill to full, fifth request dropped.
    for (int i = 1; i <= 5; i++) step(W'(i), 0, 0, 1, 0);
    chk("fill_full", 32'(full), 32'h1);
    chk("fill_head", 32'(out_data), 32'h1);
`ifdef CNT_SNAP_DROP_CNT_EN
    chk("fill_drop", 32'(drop_cnt), 32'h1);
`endif

    // Push while full with a pop in the same cycle.
    step(4'h9, 0, 0, 1, 1);
    chk("fullpp_lvl", 32'(level), 32'h4);
    chk("fullpp_head", 32'(out_data), 32'h2);
    for (int i = 0; i < 4; i++) step(4'h0, 0, 0, 0, 1);
    chk("drain_empty", 32'(empty), 32'h1);

    // Reset with entries stored.
    for (int i = 0; i < 3; i++) step(W'(i + 10), 0, 1, 1, 0);
    chk("pre_rst_lvl", 32'(level), 32'h3);
    rstn = 1'b0;
    #1;
    mq.delete(); m_roll = 1'b0; m_drop = 0;
    chk("rst_lvl", 32'(level), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_valid", 32'(out_valid), 32'h0);
    check_all();
    @(negedge clk);
    step(4'h3, 0, 0, 0, 0);
    rstn = 1'b1;
    step(4'h5, 1, 0, 0, 0);
    chk("post_rst_ev", 32'(out_src), 32'h1);
    chk("post_rst_dat", 32'(out_data), 32'h5);

    // Head stays stable while stalled.
    step(4'h7, 1, 1, 1, 0);
    hold = mq[0];
    for (int i = 0; i < 4; i++) begin
      step(4'($urandom), 1, 1'($urandom), 1'($urandom), 0);
      chk("hold_data", 32'(out_data), 32'(hold.d));
      chk("hold_src", 32'(out_src), 32'(hold.s));
      chk("hold_dir", 32'(out_dir), 32'(hold.dir));
    end

    // Random traffic.
    r_roll = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r_roll = ~r_roll;
      step(4'($urandom), r_roll, 1'($urandom),
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
